timer_peripheral: RTL

Memory-mapped peripheral responder on the pipeline core's data bus: decodes the MEM-stage address/read/write strobes, serves the timer, LED, switch, 7-segment and system-tick registers, and drives the core's interrupt input. It sits beside data RAM; the top-level mux selects `oMemReadData` for addresses in the `BASE_ADDR` window.

---
 rtl/timer_peripheral.sv | 136 +++++++++++++
 1 files changed

// File: rtl/timer_peripheral.sv
// rtl/timer_peripheral.sv - memory-mapped timer, LED, switch, 7-segment and system-tick responder
//
// Ports:
//   clk            : single clock, all state updates on the rising edge
//   reset          : asynchronous active-low reset, clears all state
//   iMemAddr       : MEM-stage byte address (bits [1:0] ignored)
//   iMemRead       : read strobe, gates oMemReadData
//   iMemWrite      : write strobe, sampled on the rising edge
//   iMemWriteData  : write data
//   oMemReadData   : combinational read data (0 when not reading or unmapped)
//   oInterrupt     : level interrupt, mirrors TCON[2]
//   iSwitch        : asynchronous board switches
//   oLed           : LED register
//   oDigi          : 7-segment register (segments [7:0], anode select [11:8])
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLed,
    output logic [11:0] oDigi
);

    localparam logic [31:0] ADDR_TH      = BASE_ADDR + 32'h00;
    localparam logic [31:0] ADDR_TL      = BASE_ADDR + 32'h04;
    localparam logic [31:0] ADDR_TCON    = BASE_ADDR + 32'h08;
    localparam logic [31:0] ADDR_LED     = BASE_ADDR + 32'h0C;
    localparam logic [31:0] ADDR_SWITCH  = BASE_ADDR + 32'h10;
    localparam logic [31:0] ADDR_DIGI    = BASE_ADDR + 32'h14;
    localparam logic [31:0] ADDR_SYSTICK = BASE_ADDR + 32'h18;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  led;
    logic [11:0] digi;
    logic [31:0] systick;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    logic hit_th, hit_tl, hit_tcon, hit_led, hit_switch, hit_digi, hit_systick;
    logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic overflow;
    logic irq_event;

    // Word-aligned decode: byte-lane bits are ignored.
    assign hit_th      = (iMemAddr[31:2] == ADDR_TH[31:2]);
    assign hit_tl      = (iMemAddr[31:2] == ADDR_TL[31:2]);
    assign hit_tcon    = (iMemAddr[31:2] == ADDR_TCON[31:2]);
    assign hit_led     = (iMemAddr[31:2] == ADDR_LED[31:2]);
    assign hit_switch  = (iMemAddr[31:2] == ADDR_SWITCH[31:2]);
    assign hit_digi    = (iMemAddr[31:2] == ADDR_DIGI[31:2]);
    assign hit_systick = (iMemAddr[31:2] == ADDR_SYSTICK[31:2]);

    assign wr_th   = iMemWrite && hit_th;
    assign wr_tl   = iMemWrite && hit_tl;
    assign wr_tcon = iMemWrite && hit_tcon;
    assign wr_led  = iMemWrite && hit_led;
    assign wr_digi = iMemWrite && hit_digi;

    assign overflow  = tcon[0] && (tl == 32'hFFFFFFFF);
    assign irq_event = overflow && tcon[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digi    <= '0;
            systick <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            systick <= systick + 32'd1;
            sw_meta <= iSwitch;
            sw_sync <= sw_meta;

            if (wr_th) begin
                th <= iMemWriteData;
            end

            // A CPU write to TL overrides both counting and reload; a reload
            // sees the old TH because th is updated non-blocking.
            if (wr_tl) begin
                tl <= iMemWriteData;
            end else if (tcon[0]) begin
                if (overflow) begin
                    tl <= th;
                end else begin
                    tl <= tl + 32'd1;
                end
            end

            // An overflow on the same edge as a software clear keeps the
            // status bit set so the event is not lost.
            if (wr_tcon) begin
                tcon <= {iMemWriteData[2] | irq_event, iMemWriteData[1:0]};
            end else if (irq_event) begin
                tcon[2] <= 1'b1;
            end

            if (wr_led) begin
                led <= iMemWriteData[7:0];
            end
            if (wr_digi) begin
                digi <= iMemWriteData[11:0];
            end
        end
    end

    always_comb begin
        oMemReadData = '0;
        if (iMemRead) begin
            if (hit_th)           oMemReadData = th;
            else if (hit_tl)      oMemReadData = tl;
            else if (hit_tcon)    oMemReadData = {29'd0, tcon};
            else if (hit_led)     oMemReadData = {24'd0, led};
            else if (hit_switch)  oMemReadData = {24'd0, sw_sync};
            else if (hit_digi)    oMemReadData = {20'd0, digi};
            else if (hit_systick) oMemReadData = systick;
        end
    end

    assign oInterrupt = tcon[2];
    assign oLed       = led;
    assign oDigi      = digi;

endmodule
